// File: rtl/alu8_seq_divider.sv
// Sequential unsigned restoring divider: one trial subtraction (A + ~B + 1) per clock,
// one quotient bit per iteration, single-cycle done pulse on completion.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | iterating, one quotient bit per edge
// DONE  | results published, done high for this cycle; ready for a new start
module alu8_seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   s_val;
    logic [WIDTH+1:0] sum;
    logic             no_borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        s_val     = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        sum       = {1'b0, s_val} + {1'b0, ~{1'b0, d_reg}} + (WIDTH + 2)'(1);
        no_borrow = sum[WIDTH+1];
        r_next    = no_borrow ? sum[WIDTH:0] : s_val;
        q_next    = {q_reg[WIDTH-2:0], no_borrow};
    end

    // Partial remainder stays below the divisor, so its top bit is never shifted back in.
    logic unused_r_msb;
    assign unused_r_msb = r_reg[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_next;
                        remainder   <= r_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    if (start) begin
                        d_reg <= divisor;
                        q_reg <= dividend;
                        r_reg <= '0;
                        cnt   <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu8_seq_divider.sv
// Scoreboard bench for alu8_seq_divider: expectations queued at issue, checked on each done pulse.
module tb_alu8_seq_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    alu8_seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        bit dbz;
        int cyc;
        int busy_cycles;
    } exp_t;

    exp_t sb[$];
    int   vectors  = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (done) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d: done=1 required no pulse", cyc);
                end else begin
                    e = sb.pop_front();
                    if (quotient !== W'(e.q) || remainder !== W'(e.r) || div_by_zero !== e.dbz) begin
                        errors++;
                        $display("FAIL result %0d/%0d: got q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                                 e.a, e.b, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
                    end
                    vectors++;
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL latency %0d/%0d: done at cycle %0d, required %0d", e.a, e.b, cyc, e.cyc);
                    end
                    vectors++;
                    if (busy_cnt != e.busy_cycles) begin
                        errors++;
                        $display("FAIL busy_cycles %0d/%0d: got %0d, required %0d", e.a, e.b, busy_cnt, e.busy_cycles);
                    end
                    if (e.b != 0) begin
                        vectors++;
                        if (int'(quotient) * e.b + int'(remainder) != e.a || int'(remainder) >= e.b) begin
                            errors++;
                            $display("FAIL invariant %0d/%0d: q=%0d r=%0d", e.a, e.b, quotient, remainder);
                        end
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    // Call just after a rising edge with the DUT ready; returns just after the accept edge.
    task automatic issue(input int a, input int b);
        exp_t e;
        e.a = a;
        e.b = b;
        e.q = (b == 0) ? 255 : a / b;
        e.r = (b == 0) ? a : a % b;
        e.dbz = (b == 0);
        e.cyc = cyc + 1 + ((b == 0) ? 0 : W);
        e.busy_cycles = (b == 0) ? 0 : W;
        sb.push_back(e);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL timeout: done=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b done=%0b q=%0d r=%0d dbz=%0b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        issue(200, 7);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_accept: busy=%0b done=%0b, required 1 0", busy, done);
        end
        wait_done();
        idle(1);
    endtask

    task automatic test_extremes();
        int tbl[4][2] = '{'{255, 1}, '{5, 9}, '{255, 255}, '{0, 3}};
        for (int i = 0; i < 4; i++) begin
            issue(tbl[i][0], tbl[i][1]);
            wait_done();
            idle(1);
        end
    endtask

    task automatic test_div_zero();
        issue(100, 0);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL div0_flags: busy=%0b done=%0b, required 0 1", busy, done);
        end
        wait_done();
        idle(1);
        issue(9, 3);
        idle(3);
        vectors++;
        if (quotient !== 8'hFF || remainder !== 8'd100 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL hold_during_run: q=%0d r=%0d dbz=%0b, required 255 100 1",
                     quotient, remainder, div_by_zero);
        end
        wait_done();
        idle(1);
    endtask

    task automatic test_back_to_back();
        issue(40, 5);
        wait_done();
        issue(81, 9);
        wait_done();
        idle(1);
        issue(200, 7);
        idle(3);
        dividend = 8'd13; divisor = 8'd2; start = 1'b1;
        idle(1);
        start = 1'b0;
        wait_done();
        idle(2);
    endtask

    task automatic test_reset_mid();
        issue(200, 7);
        idle(3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%0b done=%0b q=%0d r=%0d dbz=%0b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        sb.delete();
        busy_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        issue(50, 6);
        wait_done();
        idle(1);
    endtask

    task automatic test_random();
        int a;
        int b;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            issue(a, b);
            wait_done();
            idle($urandom_range(0, 2));
        end
        idle(3);
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
